parking_lot_ctrl: RTL and testbench

Multi-lane parking-lot occupancy controller. Each of `LANES` lanes has a sensor pair (`a` outer, `b` inner) and its own direction-tracking state machine, which recognises complete entry and exit passages and tolerates a car reversing partway through. Passages from all lanes are merged into a saturating occupancy counter with full/empty flags. The block generalises the single-lane exit detector to N lanes, both directions, sequence-error reporting and occupancy tracking.

---
 rtl/parking_lot_ctrl.sv | 120 ++++++++++++
 tb/tb_parking_lot_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// Multi-lane parking-lot occupancy controller: one direction-tracking FSM per
// sensor lane, merged into a saturating occupancy counter with full/empty flags.
module parking_lot_ctrl #(
    parameter int LANES    = 2,
    parameter int CAPACITY = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    output logic [LANES-1:0] enter_evt,
    output logic [LANES-1:0] exit_evt,
    output logic [LANES-1:0] lane_err,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             reject
);

    localparam int EW = $clog2(LANES + 1);
    localparam int SW = CNT_W + EW + 1;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        ERR  = 3'd7
    } lane_t;

    // Per-lane state is kept as a named array so checkers can bind to it.
    lane_t lane_state [LANES];
    lane_t lane_next  [LANES];

    logic [LANES-1:0]      enter_now;
    logic [LANES-1:0]      exit_now;
    logic [LANES-1:0]      err_now;
    logic [EW-1:0]         e_cnt;
    logic [EW-1:0]         x_cnt;
    logic signed [SW-1:0]  sum;

    // Each state accepts its own pattern (stay), the next one in its passage
    // (advance) or the previous one (step back); anything else is an error.
    function automatic lane_t step_lane(input lane_t st, input logic [1:0] p);
        lane_t n;
        n = ERR;
        unique case (st)
            IDLE: if (p == 2'b00) n = IDLE; else if (p == 2'b10) n = EN1;
                  else if (p == 2'b01) n = EX1;
            EN1:  if (p == 2'b10) n = EN1; else if (p == 2'b11) n = EN2;
                  else if (p == 2'b00) n = IDLE;
            EN2:  if (p == 2'b11) n = EN2; else if (p == 2'b01) n = EN3;
                  else if (p == 2'b10) n = EN1;
            EN3:  if (p == 2'b01) n = EN3; else if (p == 2'b00) n = IDLE;
                  else if (p == 2'b11) n = EN2;
            EX1:  if (p == 2'b01) n = EX1; else if (p == 2'b11) n = EX2;
                  else if (p == 2'b00) n = IDLE;
            EX2:  if (p == 2'b11) n = EX2; else if (p == 2'b10) n = EX3;
                  else if (p == 2'b01) n = EX1;
            EX3:  if (p == 2'b10) n = EX3; else if (p == 2'b00) n = IDLE;
                  else if (p == 2'b11) n = EX2;
            ERR:  if (p == 2'b00) n = IDLE;
            default: n = ERR;
        endcase
        return n;
    endfunction

    always_comb begin
        e_cnt = '0;
        x_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_next[i] = step_lane(lane_state[i], {a[i], b[i]});
            enter_now[i] = (lane_state[i] == EN3) && ({a[i], b[i]} == 2'b00);
            exit_now[i]  = (lane_state[i] == EX3) && ({a[i], b[i]} == 2'b00);
            err_now[i]   = (lane_next[i] == ERR) && (lane_state[i] != ERR);
            e_cnt        = e_cnt + EW'(enter_now[i]);
            x_cnt        = x_cnt + EW'(exit_now[i]);
        end
        sum = $signed({{(SW-CNT_W){1'b0}}, count})
            + $signed({{(SW-EW){1'b0}}, e_cnt})
            - $signed({{(SW-EW){1'b0}}, x_cnt});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) lane_state[i] <= IDLE;
            enter_evt <= '0;
            exit_evt  <= '0;
            lane_err  <= '0;
            count     <= '0;
            reject    <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) lane_state[i] <= lane_next[i];
            enter_evt <= enter_now;
            exit_evt  <= exit_now;
            lane_err  <= err_now;
            // Entries and exits on the same edge net out before clamping.
            if (sum > CAP_S) begin
                count  <= CAP_C;
                reject <= 1'b1;
            end else if (sum < 0) begin
                count  <= '0;
                reject <= 1'b1;
            end else begin
                count  <= sum[CNT_W-1:0];
                reject <= 1'b0;
            end
        end
    end

    assign full  = (count == CAP_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Bench for parking_lot_ctrl: directed passages then random sensor walks, every
// cycle compared against a passage-position model of lanes and occupancy.
module tb_parking_lot_ctrl;

    localparam int LANES    = 2;
    localparam int CAPACITY = 3;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [LANES-1:0] a = '0;
    logic [LANES-1:0] b = '0;
    logic [LANES-1:0] enter_evt;
    logic [LANES-1:0] exit_evt;
    logic [LANES-1:0] lane_err;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             reject;

    parking_lot_ctrl #(.LANES(LANES), .CAPACITY(CAPACITY), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .enter_evt(enter_evt), .exit_evt(exit_evt), .lane_err(lane_err),
        .count(count), .full(full), .empty(empty), .reject(reject)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Passage tables: index k is the pattern at position k of the passage.
    logic [1:0] en_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] ex_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    int m_pos [LANES];
    int m_dir [LANES];
    bit m_err [LANES];
    int m_cnt;

    logic [LANES-1:0] exp_enter, exp_exit, exp_err;
    logic             exp_reject;
    logic [CNT_W-1:0] exp_q [$];

    int         g_dir [LANES];
    logic [1:0] g_pat [LANES];

    function automatic logic [1:0] seq_pat(input int d, input int k);
        int kk;
        kk = ((k % 4) + 4) % 4;
        return (d > 0) ? en_seq[kk] : ex_seq[kk];
    endfunction

    task automatic model_lane(input int i, input logic [1:0] p,
                              output bit ent, output bit ex, output bit er);
        ent = 0; ex = 0; er = 0;
        if (m_err[i]) begin
            if (p == 2'b00) m_err[i] = 0;
        end else if (m_pos[i] == 0) begin
            if (p == 2'b10) begin m_dir[i] = 1;  m_pos[i] = 1; end
            else if (p == 2'b01) begin m_dir[i] = -1; m_pos[i] = 1; end
            else if (p == 2'b11) begin m_err[i] = 1; er = 1; end
        end else if (p == seq_pat(m_dir[i], m_pos[i])) begin
            // holding the current pattern
        end else if (p == seq_pat(m_dir[i], m_pos[i] + 1)) begin
            if (m_pos[i] == 3) begin
                m_pos[i] = 0;
                if (m_dir[i] > 0) ent = 1; else ex = 1;
            end else begin
                m_pos[i] = m_pos[i] + 1;
            end
        end else if (p == seq_pat(m_dir[i], m_pos[i] - 1)) begin
            m_pos[i] = m_pos[i] - 1;
        end else begin
            m_err[i] = 1; m_pos[i] = 0; er = 1;
        end
    endtask

    task automatic model_edge(input logic [1:0] p0, input logic [1:0] p1);
        bit ent, ex, er;
        int e, x, nxt;
        logic [1:0] pp [LANES];
        pp[0] = p0; pp[1] = p1;
        exp_enter = '0; exp_exit = '0; exp_err = '0; exp_reject = 0;
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                m_pos[i] = 0; m_dir[i] = 0; m_err[i] = 0;
            end
            m_cnt = 0;
            return;
        end
        e = 0; x = 0;
        for (int i = 0; i < LANES; i++) begin
            model_lane(i, pp[i], ent, ex, er);
            exp_enter[i] = ent; exp_exit[i] = ex; exp_err[i] = er;
            e += int'(ent); x += int'(ex);
        end
        nxt = m_cnt + e - x;
        if (nxt > CAPACITY) begin m_cnt = CAPACITY; exp_reject = 1; end
        else if (nxt < 0) begin m_cnt = 0; exp_reject = 1; end
        else m_cnt = nxt;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [1:0] p0, input logic [1:0] p1);
        logic [CNT_W-1:0] ec;
        a = {p1[1], p0[1]};
        b = {p1[0], p0[0]};
        model_edge(p0, p1);
        exp_q.push_back(CNT_W'(m_cnt));
        @(posedge clk);
        #1;
        ec = exp_q.pop_front();
        chk("enter_evt", 8'(enter_evt), 8'(exp_enter));
        chk("exit_evt",  8'(exit_evt),  8'(exp_exit));
        chk("lane_err",  8'(lane_err),  8'(exp_err));
        chk("reject",    8'(reject),    8'(exp_reject));
        chk("count",     8'(count),     8'(ec));
        chk("full",      8'(full),      8'(ec == CNT_W'(CAPACITY)));
        chk("empty",     8'(empty),     8'(ec == '0));
    endtask

    task automatic hold(input logic [1:0] p0, input logic [1:0] p1, input int n);
        repeat (n) tick(p0, p1);
    endtask

    task automatic entry0();
        hold(2'b10, 2'b00, 2); hold(2'b11, 2'b00, 2);
        hold(2'b01, 2'b00, 2); hold(2'b00, 2'b00, 2);
    endtask

    task automatic exit1();
        hold(2'b00, 2'b01, 2); hold(2'b00, 2'b11, 2);
        hold(2'b00, 2'b10, 2); hold(2'b00, 2'b00, 2);
    endtask

    function automatic logic [1:0] walk(input int d, input logic [1:0] p, input int step);
        for (int k = 0; k < 4; k++)
            if (seq_pat(d, k) == p) return seq_pat(d, k + step);
        return 2'b00;
    endfunction

    initial begin
        reset = 1'b1;
        tick(2'b00, 2'b00);
        tick(2'b11, 2'b10);
        reset = 1'b0;
        hold(2'b00, 2'b00, 2);

        // single entry on lane 0
        entry0();
        // lane 1 reverses mid-exit and aborts, then a full exit
        hold(2'b00, 2'b01, 2); hold(2'b00, 2'b11, 2);
        hold(2'b00, 2'b01, 2); hold(2'b00, 2'b00, 2);
        exit1();
        // exit while empty clamps at zero
        exit1();
        // illegal jump on lane 0, recovery, then a valid entry
        hold(2'b11, 2'b00, 2); hold(2'b10, 2'b00, 1); hold(2'b01, 2'b00, 1);
        hold(2'b00, 2'b00, 2);
        entry0();
        // saturation: fill to capacity and one more
        entry0(); entry0(); entry0();
        // simultaneous entry (lane 0) and exit (lane 1) while full
        tick(2'b10, 2'b01); tick(2'b11, 2'b11); tick(2'b01, 2'b10);
        tick(2'b00, 2'b00);
        // drain to 1, then two lanes enter together
        exit1(); exit1();
        tick(2'b10, 2'b10); tick(2'b11, 2'b11); tick(2'b01, 2'b01);
        tick(2'b00, 2'b00);
        // reset with lane 0 mid-entry at 11
        tick(2'b10, 2'b00); tick(2'b11, 2'b00);
        reset = 1'b1;
        tick(2'b11, 2'b00);
        reset = 1'b0;
        hold(2'b11, 2'b00, 2);
        hold(2'b00, 2'b00, 2);

        // random sensor walks biased toward legal passages
        for (int i = 0; i < LANES; i++) begin g_dir[i] = 1; g_pat[i] = 2'b00; end
        repeat (600) begin
            for (int i = 0; i < LANES; i++) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (g_pat[i] == 2'b00 && r < 12)
                    g_dir[i] = ($urandom_range(0, 1) == 0) ? 1 : -1;
                if (r < 12)      g_pat[i] = walk(g_dir[i], g_pat[i], 1);
                else if (r < 17) g_pat[i] = g_pat[i];
                else if (r < 19) g_pat[i] = walk(g_dir[i], g_pat[i], -1);
                else             g_pat[i] = 2'($urandom_range(0, 3));
            end
            tick(g_pat[0], g_pat[1]);
        end
        hold(2'b00, 2'b00, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
